// File: rtl/pkt_gen_sequencer.sv
// rtl/pkt_gen_sequencer.sv - packet generator sweep sequencer (Avalon-MM master)
//
// Purpose:
//   Drives a packet-generator slave through a sweep of payload lengths. For each
//   step it programs length, seed and counter clear, starts the generator, polls
//   the packet counter until cfg_pkts packets have gone out, stops the generator
//   and polls the run flag until the generator is idle. The length advances by
//   cfg_len_step (mod 2^16) after each step until cfg_steps steps are done.
//
// Ports:
//   csi_clock_clk        clock
//   csi_clock_reset      asynchronous, active-high reset
//   start                begin sweep (pulse); honoured only when idle/done
//   cfg_len_start[15:0]  first payload length
//   cfg_len_step[15:0]   length increment per step
//   cfg_steps[7:0]       number of lengths to run
//   cfg_seed[31:0]       PRBS seed written every step
//   cfg_pkts[31:0]       packets to wait for per step
//   avm_m0_*             Avalon-MM master to generator, zero-latency reads
//   busy, done, error    status; done and error hold until the next start
//   cur_len[15:0]        length of the current step
//   step_idx[7:0]        index of the current step
//
// Build option:
//   PKT_GEN_SEQUENCER_TIMEOUT_EN - adds a poll watchdog of TIMEOUT_CYCLES clocks;
//   on expiry it raises error, writes 0 to the control register and ends in DONE.

module pkt_gen_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        csi_clock_clk,
  input  logic        csi_clock_reset,
  input  logic        start,
  input  logic [15:0] cfg_len_start,
  input  logic [15:0] cfg_len_step,
  input  logic [7:0]  cfg_steps,
  input  logic [31:0] cfg_seed,
  input  logic [31:0] cfg_pkts,
  output logic        avm_m0_write,
  output logic        avm_m0_read,
  output logic [1:0]  avm_m0_address,
  output logic [3:0]  avm_m0_byteenable,
  output logic [31:0] avm_m0_writedata,
  input  logic [31:0] avm_m0_readdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] cur_len,
  output logic [7:0]  step_idx
);

  // Generator register map
  localparam logic [1:0] REG_CTRL  = 2'd0;  // bit0 go (write), bit1 running (read)
  localparam logic [1:0] REG_LEN   = 2'd1;
  localparam logic [1:0] REG_SEED  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;  // write clears, read returns sent count

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_LEN,
    ST_WR_SEED,
    ST_WR_CLR,
    ST_WR_GO,
    ST_POLL_CNT,
    ST_WR_STOP,
    ST_POLL_RUN,
    ST_NEXT,
    ST_DONE
`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
    , ST_ABORT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cur_len_q, cur_len_d;
  logic [7:0]  step_idx_q, step_idx_d;
  logic [15:0] len_step_q;
  logic [7:0]  steps_q;
  logic [31:0] seed_q;
  logic [31:0] pkts_q;
  logic        load_cfg;

`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
  logic [23:0] tmo_q;
  logic        tmo_hit;
  logic        error_q;

  // tmo_q counts poll cycles already spent in the current poll state, so the
  // limit is hit on the TIMEOUT_CYCLES-th consecutive cycle without an exit.
  assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 24'd1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Next state, datapath updates and bus outputs
  always_comb begin
    state_d           = state_q;
    cur_len_d         = cur_len_q;
    step_idx_d        = step_idx_q;
    load_cfg          = 1'b0;
    avm_m0_write      = 1'b0;
    avm_m0_read       = 1'b0;
    avm_m0_address    = 2'd0;
    avm_m0_byteenable = 4'h0;
    avm_m0_writedata  = 32'd0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_cfg   = 1'b1;
          cur_len_d  = cfg_len_start;
          step_idx_d = 8'd0;
          // An empty sweep completes immediately with no bus traffic.
          state_d    = (cfg_steps == 8'd0) ? ST_DONE : ST_WR_LEN;
        end
      end

      ST_WR_LEN: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_LEN;
        avm_m0_writedata  = {16'h0000, cur_len_q};
        state_d           = ST_WR_SEED;
      end

      ST_WR_SEED: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_SEED;
        avm_m0_writedata  = seed_q;
        state_d           = ST_WR_CLR;
      end

      ST_WR_CLR: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_COUNT;
        state_d           = ST_WR_GO;
      end

      ST_WR_GO: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_CTRL;
        avm_m0_writedata  = 32'h0000_0001;
        state_d           = ST_POLL_CNT;
      end

      ST_POLL_CNT: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = REG_COUNT;
        // Readdata is valid in the same cycle, so the exit decision is made now.
        if (avm_m0_readdata >= pkts_q) begin
          state_d = ST_WR_STOP;
        end
`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ST_ABORT;
        end
`endif
      end

      ST_WR_STOP: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_CTRL;
        state_d           = ST_POLL_RUN;
      end

      ST_POLL_RUN: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = REG_CTRL;
        if (!avm_m0_readdata[1]) begin
          state_d = ST_NEXT;
        end
`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ST_ABORT;
        end
`endif
      end

      ST_NEXT: begin
        step_idx_d = step_idx_q + 8'd1;
        cur_len_d  = cur_len_q + len_step_q;
        state_d    = (step_idx_d == steps_q) ? ST_DONE : ST_WR_LEN;
      end

`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
      ST_ABORT: begin
        // Same transaction as WR_STOP: leave the generator stopped.
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 4'hF;
        avm_m0_address    = REG_CTRL;
        state_d           = ST_DONE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
    if (csi_clock_reset) begin
      state_q    <= ST_IDLE;
      cur_len_q  <= 16'd0;
      step_idx_q <= 8'd0;
      len_step_q <= 16'd0;
      steps_q    <= 8'd0;
      seed_q     <= 32'd0;
      pkts_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cur_len_q  <= cur_len_d;
      step_idx_q <= step_idx_d;
      if (load_cfg) begin
        len_step_q <= cfg_len_step;
        steps_q    <= cfg_steps;
        seed_q     <= cfg_seed;
        pkts_q     <= cfg_pkts;
      end
    end
  end

`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
    if (csi_clock_reset) begin
      tmo_q   <= 24'd0;
      error_q <= 1'b0;
    end else begin
      // Staying in a poll state counts; any transition restarts from zero.
      if ((state_q == ST_POLL_CNT || state_q == ST_POLL_RUN) && state_d == state_q) begin
        tmo_q <= tmo_q + 24'd1;
      end else begin
        tmo_q <= 24'd0;
      end

      if (load_cfg) begin
        error_q <= 1'b0;
      end else if (state_d == ST_ABORT) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign cur_len  = cur_len_q;
  assign step_idx = step_idx_q;

endmodule

// File: tb/tb_pkt_gen_sequencer.sv
// tb/tb_pkt_gen_sequencer.sv - self-checking bench for pkt_gen_sequencer

module tb_pkt_gen_sequencer;

  localparam int TMO    = 100;
  localparam int BUDGET = 4000;
  localparam int K_WR   = 0;
  localparam int K_PCNT = 1;
  localparam int K_PRUN = 2;
  localparam int K_NX   = 3;

  typedef struct {
    int          kind;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [7:0]  step;
    logic [15:0] len;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len_start;
  logic [15:0] cfg_len_step;
  logic [7:0]  cfg_steps;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_pkts;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] cur_len;
  logic [7:0]  step_idx;

  int   vectors = 0;
  int   errors  = 0;
  bit   tmo_en  = 1'b0;
  ent_t q[$];

  pkt_gen_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .csi_clock_clk     (clk),
    .csi_clock_reset   (rst),
    .start             (start),
    .cfg_len_start     (cfg_len_start),
    .cfg_len_step      (cfg_len_step),
    .cfg_steps         (cfg_steps),
    .cfg_seed          (cfg_seed),
    .cfg_pkts          (cfg_pkts),
    .avm_m0_write      (write),
    .avm_m0_read       (read),
    .avm_m0_address    (address),
    .avm_m0_byteenable (byteenable),
    .avm_m0_writedata  (writedata),
    .avm_m0_readdata   (readdata),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .cur_len           (cur_len),
    .step_idx          (step_idx)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input int k, input logic [1:0] a, input logic [31:0] d,
                              input logic [7:0] s, input logic [15:0] l);
    ent_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.step = s;
    e.len  = l;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus"}, 32'({write, read, address, byteenable}), 32'd0);
    chk({tag, "_wdata"}, writedata, 32'd0);
    chk({tag, "_status"}, 32'({busy, done, error, step_idx, cur_len}), 32'd0);
  endtask

  // Expected bus activity of one sweep, step by step, from the sequencing rules.
  task automatic build(input logic [15:0] ls, input logic [15:0] st, input logic [7:0] n,
                       input logic [31:0] seed);
    logic [15:0] len;
    q.delete();
    for (int i = 0; i < int'(n); i++) begin
      len = 16'(32'(ls) + 32'(i) * 32'(st));
      q.push_back(mk(K_WR,   2'd1, {16'h0, len}, 8'(i), len));
      q.push_back(mk(K_WR,   2'd2, seed,         8'(i), len));
      q.push_back(mk(K_WR,   2'd3, 32'd0,        8'(i), len));
      q.push_back(mk(K_WR,   2'd0, 32'd1,        8'(i), len));
      q.push_back(mk(K_PCNT, 2'd3, 32'd0,        8'(i), len));
      q.push_back(mk(K_WR,   2'd0, 32'd0,        8'(i), len));
      q.push_back(mk(K_PRUN, 2'd0, 32'd0,        8'(i), len));
      q.push_back(mk(K_NX,   2'd0, 32'd0,        8'(i), len));
    end
  endtask

  task automatic sweep(input logic [15:0] ls, input logic [15:0] st, input logic [7:0] n,
                       input logic [31:0] seed, input logic [31:0] pkts, input bit noise,
                       input int rst_at, input bit zero_poll);
    ent_t        e;
    logic [15:0] fin_len;
    logic [7:0]  fin_step;
    logic        fin_err;
    logic [31:0] rd;
    int          pc;
    int          cycles;
    bit          fin;
    bit          ex;

    build(ls, st, n, seed);
    fin_len  = 16'(32'(ls) + 32'(n) * 32'(st));
    fin_step = n;
    fin_err  = 1'b0;

    cfg_len_start = ls;
    cfg_len_step  = st;
    cfg_steps     = n;
    cfg_seed      = seed;
    cfg_pkts      = pkts;
    start         = 1'b1;
    @(negedge clk);

    pc     = 0;
    cycles = 0;
    fin    = 1'b0;
    while (!fin) begin
      start    = 1'b0;
      readdata = $urandom;
      chk("rd_wr_excl", 32'(read & write), 32'd0);
      if (q.size() == 0) begin
        chk("end_done",  32'(done),     32'd1);
        chk("end_busy",  32'(busy),     32'd0);
        chk("end_bus",   32'({write, read}), 32'd0);
        chk("end_step",  32'(step_idx), 32'(fin_step));
        chk("end_len",   32'(cur_len),  32'(fin_len));
        chk("end_error", 32'(error),    32'(fin_err));
        fin = 1'b1;
      end else begin
        e = q[0];
        if (rst_at >= 0 && e.kind == K_PCNT && int'(e.step) == rst_at) begin
          rst = 1'b1;
          #1;
          chk_zero("rst_async");
          @(negedge clk);
          chk_zero("rst_held");
          rst = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk_zero("rst_no_start");
          end
          return;
        end
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'd0);
        chk("cur_len", 32'(cur_len), 32'(e.len));
        chk("step_idx", 32'(step_idx), 32'(e.step));
        case (e.kind)
          K_WR: begin
            chk("wr_strobe", 32'({write, read}), 32'h2);
            chk("wr_addr", 32'(address), 32'(e.addr));
            chk("wr_data", writedata, e.data);
            chk("wr_be", 32'(byteenable), 32'hF);
            void'(q.pop_front());
          end
          K_PCNT, K_PRUN: begin
            chk("rd_strobe", 32'({write, read}), 32'h1);
            chk("rd_addr", 32'(address), 32'(e.addr));
            if (e.kind == K_PCNT) begin
              if (zero_poll) begin
                rd = 32'd0;
              end else begin
                case ($urandom_range(0, 2))
                  0:       rd = $urandom;
                  1:       rd = pkts + 32'($urandom_range(0, 2));
                  default: rd = pkts - 32'($urandom_range(1, 3));
                endcase
              end
              ex = (rd >= pkts);
            end else begin
              rd    = $urandom;
              rd[1] = ($urandom_range(0, 2) == 0);
              ex    = !rd[1];
            end
            readdata = rd;
            if (ex) begin
              void'(q.pop_front());
              pc = 0;
            end else begin
              pc++;
              if (tmo_en && pc == TMO) begin
                fin_len  = e.len;
                fin_step = e.step;
                fin_err  = 1'b1;
                q.delete();
                q.push_back(mk(K_WR, 2'd0, 32'd0, e.step, e.len));
                pc = 0;
              end
            end
          end
          default: begin
            chk("next_bus", 32'({write, read}), 32'd0);
            void'(q.pop_front());
          end
        endcase
        if (noise && $urandom_range(0, 2) == 0) begin
          start         = 1'b1;
          cfg_len_start = 16'($urandom);
          cfg_len_step  = 16'($urandom);
          cfg_steps     = 8'($urandom);
          cfg_seed      = $urandom;
          cfg_pkts      = $urandom;
        end
        cycles++;
        if (cycles > BUDGET) begin
          chk("sweep_budget", 32'(q.size()), 32'd0);
          fin = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
    tmo_en = 1'b1;
`endif
    rst           = 1'b1;
    start         = 1'b0;
    cfg_len_start = 16'd0;
    cfg_len_step  = 16'd0;
    cfg_steps     = 8'd0;
    cfg_seed      = 32'd0;
    cfg_pkts      = 32'd0;
    readdata      = 32'd0;
    #1;
    chk_zero("reset_state");
    @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle_no_start");

    // Reference sweep, then the same with start pulses and cfg churn while busy
    sweep(16'd16, 16'd4, 8'd3, 32'h3355_7799, 32'd5, 1'b0, -1, 1'b0);
    sweep(16'd16, 16'd4, 8'd3, 32'h3355_7799, 32'd5, 1'b1, -1, 1'b0);
    // Length wrap: second length is 0x0002
    sweep(16'hFFFE, 16'd4, 8'd2, 32'hA5A5_0001, 32'd3, 1'b0, -1, 1'b0);
    // Empty sweep: DONE next clock, no bus activity
    sweep(16'd100, 16'd1, 8'd0, 32'h1, 32'd7, 1'b0, -1, 1'b0);
    // Reset while polling the count of the second step, then a full sweep
    sweep(16'd64, 16'd8, 8'd3, 32'hDEAD_BEEF, 32'd9, 1'b0, 1, 1'b0);
    sweep(16'd64, 16'd8, 8'd3, 32'hDEAD_BEEF, 32'd9, 1'b0, -1, 1'b0);
    // Zero packets leaves the count poll on its first cycle
    sweep(16'd1, 16'd1, 8'd2, 32'h0, 32'd0, 1'b0, -1, 1'b0);
    // Largest packet target
    sweep(16'd8, 16'd2, 8'd1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      sweep(16'($urandom), 16'($urandom), 8'($urandom_range(0, 6)), $urandom,
            32'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)), -1, 1'b0);
    end

`ifdef PKT_GEN_SEQUENCER_TIMEOUT_EN
    // Count never arrives: watchdog fires, stop write, DONE with error
    sweep(16'd16, 16'd4, 8'd3, 32'h3355_7799, 32'd5, 1'b0, -1, 1'b1);
    // Next start clears the sticky error
    sweep(16'd16, 16'd4, 8'd1, 32'h3355_7799, 32'd5, 1'b0, -1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pkt_gen_sequencer.md
PKT_GEN_SEQUENCER -- requirements
Module: pkt_gen_sequencer

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 24'd1000000: poll watchdog limit in clocks.
REQ-002 SHALL provide ports: csi_clock_clk in 1 clock; csi_clock_reset in 1 reset, asynchronous, active-high.
REQ-003 SHALL provide ports: start in 1 begin sweep (pulse); cfg_len_start in 16 first payload length; cfg_len_step in 16 length increment; cfg_steps in 8 number of lengths run; cfg_seed in 32 PRBS seed; cfg_pkts in 32 packets per step.
REQ-004 SHALL provide Avalon-MM master to the generator slave: avm_m0_write out 1; avm_m0_read out 1; avm_m0_address out 2; avm_m0_byteenable out 4; avm_m0_writedata out 32; avm_m0_readdata in 32, zero-latency (valid in the cycle read is high), no waitrequest.
REQ-005 SHALL provide status: busy out 1; done out 1 (sticky until next start); error out 1 (timeout, sticky until next start); cur_len out 16; step_idx out 8.

Function
REQ-006 SHALL sample all cfg_* on start in IDLE/DONE; start while busy ignored.
REQ-007 SHALL sequence states IDLE -> WR_LEN -> WR_SEED -> WR_CLR -> WR_GO -> POLL_CNT -> WR_STOP -> POLL_RUN -> NEXT -> (WR_LEN | DONE); DONE -> WR_LEN on start.
REQ-008 Each WR_* state SHALL last exactly one clock with avm_m0_write=1, byteenable=4'hF.
REQ-009 WR_LEN: address 1, writedata {16'h0, cur_len}; WR_SEED: address 2, cfg_seed; WR_CLR: address 3, 0; WR_GO: address 0, 32'h1; WR_STOP: address 0, 32'h0.
REQ-010 POLL_CNT SHALL assert read, address 3, every cycle; exit to WR_STOP in the cycle readdata >= cfg_pkts (unsigned 32-bit).
REQ-011 POLL_RUN SHALL assert read, address 0, every cycle; exit to NEXT in the cycle readdata[1]==0.
REQ-012 NEXT (one clock): step_idx+1; cur_len <= cur_len + cfg_len_step modulo 2^16 (wrap, no saturation); go DONE if new step_idx == cfg_steps, else WR_LEN.
REQ-013 cfg_steps==0 SHALL go start -> DONE in one clock, no bus transactions.
REQ-014 cfg_pkts==0 SHALL leave POLL_CNT on its first cycle.
REQ-015 read and write SHALL never be high in the same cycle; outside active states both 0, address/writedata 0.
REQ-016 busy=1 in every state except IDLE and DONE; done=1 only in DONE.
REQ-017 First write SHALL occur the clock after start is sampled (latency 1).
REQ-018 cur_len loaded with cfg_len_start and step_idx with 0 on accepted start.

Reset
REQ-019 csi_clock_reset SHALL force state IDLE, all outputs 0, counters 0, at any time including mid-sweep; no stop write is issued.
REQ-020 After reset release, first action SHALL require a new start.

Configuration
REQ-021 Macro PKT_GEN_SEQUENCER_TIMEOUT_EN defined: a counter cleared on entry to each POLL state increments per poll cycle; reaching TIMEOUT_CYCLES sets error, issues one WR_STOP-style write (address 0, 0), then DONE with done=1.
REQ-022 Macro undefined: no watchdog logic, error tied 0, polls wait indefinitely.

Verification
REQ-023 Reset, cfg_len_start=16, step=4, steps=3, seed=0x33557799, pkts=5, start pulse -> writes len 16/20/24, each followed by seed, clear, go=1, count poll to 5, go=0; done=1, step_idx=3.
REQ-024 cfg_len_start=0xFFFE, step=4, steps=2 -> second WR_LEN writedata 0x00000002.
REQ-025 cfg_steps=0, start -> done=1 next clock, no read/write ever asserted.
REQ-026 Reset asserted during POLL_CNT -> next clock all outputs 0, state IDLE; start afterward runs full sequence from WR_LEN.
REQ-027 With PKT_GEN_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=100, readdata held 0 in POLL_CNT -> error=1 after 100 poll cycles, one write address 0 data 0, done=1.
REQ-028 start pulsed while busy -> ignored, sweep results identical to REQ-023.
